dt1_hazard_ctrl: RTL and testbench
==================================

// Module: dt1_hazard_ctrl
// PURPOSE
//  Pipeline hazard controller for the dt1 RV32I 5-stage core. Sits beside the IF/ID/IE/IM/IW
//  registers and drives their stall/flush enables plus the Execute-stage forwarding selects.
//  Resolves RAW hazards (forward or load-use stall) and control hazards (taken branch/jump flush).
//  Sequences data-memory wait states and halts the core on a data-memory timeout.
// PARAMETERS
//  MEM_TIMEOUT  16  max consecutive wait cycles on a data-memory access before HALT (>=2)
//  CNT_W        32  width of the stall-cycle performance counter
// PORTS
//  clk          in   1      core clock; single clock domain
//  rst          in   1      synchronous, active-high reset
//  Rs1D,Rs2D    in   5      source regs of the instruction in Decode
//  Rs1E,Rs2E    in   5      source regs of the instruction in Execute
//  RdE          in   5      dest reg in Execute
//  ResultSrcE   in   2      result select in Execute; 2'b01 = load
//  PCSrcE       in   1      taken branch/jump resolved in Execute
//  RdM          in   5      dest reg in Memory
//  RegWriteM    in   1      Memory-stage instruction writes the regfile
//  RdW          in   5      dest reg in Writeback
//  RegWriteW    in   1      Writeback-stage instruction writes the regfile
//  MemReqM      in   1      data-memory access active in Memory
//  MemAckM      in   1      data memory completes the access this cycle
//  ForwardAE    out  2      SrcA select: 00 RD1E, 01 ResultW, 10 ALUResultM
//  ForwardBE    out  2      SrcB select: same encoding
//  StallF,StallD,StallE,StallM  out 1 each  hold the PC / IF-ID / ID-IE / IE-IM register
//  FlushD,FlushE,FlushW         out 1 each  zero the IF-ID / ID-IE / IM-IW register (bubble)
//  HaltO        out  1      sticky: core halted on memory timeout
//  StallCycles  out  CNT_W  count of cycles with StallF=1
// BEHAVIOUR
//  - Reset (rst=1): state<=RUN, wait counter<=0, StallCycles<=0, HaltO<=0. While rst=1: all
//    Flush*=1, all Stall*=0, Forward*=00.
//  - Forwarding (combinational): ForwardAE=10 if RegWriteM && RdM!=0 && RdM==Rs1E; else 01 if
//    RegWriteW && RdW!=0 && RdW==Rs1E; else 00. M beats W. Same rules for ForwardBE/Rs2E.
//  - lwStall = ResultSrcE==2'b01 && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
//  - memWait = MemReqM && !MemAckM.
//  - States: RUN, MEMWAIT, HALT. Outputs are combinational from state + inputs; zero latency.
//  - RUN/MEMWAIT, memWait=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
//    Overrides lwStall and PCSrcE; both are re-evaluated once the stall releases (E is held).
//  - memWait=0, PCSrcE=1: FlushD=FlushE=1, StallF=StallD=0 (lwStall suppressed).
//  - memWait=0, PCSrcE=0, lwStall=1: StallF=StallD=1, FlushE=1.
//  - Otherwise all Stall*/Flush* = 0.
//  - RUN->MEMWAIT when memWait=1; wait counter counts waited cycles: 1 on the first, +1 each
//    MEMWAIT cycle.
//  - MEMWAIT->RUN on MemAckM=1 (stall released that same cycle); counter<=0.
//  - MEMWAIT->HALT when the counter reaches MEM_TIMEOUT and MemAckM=0.
//  - A MemAckM arriving in that same cycle wins (->RUN).
//  - HALT: HaltO=1, StallF/D/E/M=1, FlushW=1, Forward*=00. Left only by rst; inputs ignored.
//  - MemReqM dropping without ack in MEMWAIT -> RUN, counter<=0 (access abandoned upstream).
//  - StallCycles += 1 each cycle StallF=1 (including HALT); wraps at 2^CNT_W.
//  - Reset mid-wait or in HALT: next cycle is RUN with counters cleared.
// STRUCTURE
//  - Shared package dt1_pkg: RESULTSRC_LOAD=2'b01, FWD_RF/FWD_W/FWD_M encodings, state
//    enum {RUN, MEMWAIT, HALT}.
//  - One natural sub-module: dt1_fwd_sel (combinational forward compare, instanced for A and B).
//  - FSM, wait counter, perf counter and stall/flush priority logic live in the top.
// TESTING
//  1. Fwd: RdM=5,RegWriteM=1,RdW=5,RegWriteW=1,Rs1E=5 -> ForwardAE=10; RdM=0 case -> 01;
//     Rs2E=0 -> ForwardBE=00.
//  2. Load-use: ResultSrcE=01,RdE=7,Rs2D=7 -> StallF=StallD=FlushE=1 one cycle; StallCycles+1.
//  3. Branch+load-use same cycle: PCSrcE=1,lwStall=1 -> FlushD=FlushE=1, StallF=StallD=0.
//  4. Mem wait: MemReqM=1, ack after 3 cycles -> StallF/D/E/M=FlushW=1 for 3 cycles, 0 on the
//     ack cycle; PCSrcE held through -> flush applied on the ack cycle.
//  5. Timeout: MEM_TIMEOUT=4, no ack -> HALT after the 4th wait cycle; HaltO stays 1 until rst.
//     Ack on the 4th cycle -> RUN, no halt.
//  6. rst asserted in MEMWAIT -> next cycle RUN, StallCycles=0, all stalls 0, flushes 1 during rst.

Source files
------------

// File: rtl/dt1_pkg.sv
// Shared definitions for the dt1 core hazard logic: result/forward encodings,
// hazard-controller states and the bundled stall/flush control word.
package dt1_pkg;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic stall_m;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  // x0 is hardwired to zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
    return (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/dt1_fwd_sel.sv
// Execute-stage operand forward select for one source register.
// The Memory-stage producer is younger than Writeback, so it wins.
module dt1_fwd_sel
  import dt1_pkg::*;
(
  input  logic [4:0] RsE_i,
  input  logic [4:0] RdM_i,
  input  logic       RegWriteM_i,
  input  logic [4:0] RdW_i,
  input  logic       RegWriteW_i,
  output logic [1:0] Fwd_o
);

  always_comb begin
    Fwd_o = FWD_RF;
    if (RegWriteM_i && reg_match(RdM_i, RsE_i)) begin
      Fwd_o = FWD_M;
    end else if (RegWriteW_i && reg_match(RdW_i, RsE_i)) begin
      Fwd_o = FWD_W;
    end
  end

endmodule

// File: rtl/dt1_hazard_ctrl.sv
// Hazard controller for the dt1 5-stage core: forwarding, load-use stall,
// branch flush, data-memory wait sequencing and timeout halt.
module dt1_hazard_ctrl
  import dt1_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemAckM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             HaltO,
  output logic [CNT_W-1:0] StallCycles
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic       mem_wait;
  logic       lw_stall;
  logic       fwd_block;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;
  hz_ctrl_t   ctrl;

  dt1_fwd_sel u_fwd_a (
    .RsE_i       (Rs1E),
    .RdM_i       (RdM),
    .RegWriteM_i (RegWriteM),
    .RdW_i       (RdW),
    .RegWriteW_i (RegWriteW),
    .Fwd_o       (fwd_a_raw)
  );

  dt1_fwd_sel u_fwd_b (
    .RsE_i       (Rs2E),
    .RdM_i       (RdM),
    .RegWriteM_i (RegWriteM),
    .RdW_i       (RdW),
    .RegWriteW_i (RegWriteW),
    .Fwd_o       (fwd_b_raw)
  );

  assign mem_wait = MemReqM && !MemAckM;
  assign lw_stall = (ResultSrcE == RESULTSRC_LOAD) &&
                    (reg_match(RdE, Rs1D) || reg_match(RdE, Rs2D));

  // Forwarding is meaningless while the pipe is being reset or is frozen in HALT.
  assign fwd_block = rst || (state_q == HALT);
  assign ForwardAE = fwd_block ? FWD_RF : fwd_a_raw;
  assign ForwardBE = fwd_block ? FWD_RF : fwd_b_raw;

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEMWAIT;
          wcnt_d  = WAIT_ONE;
        end
      end
      MEMWAIT: begin
        // An ack, or the request being withdrawn, both end the wait; ack beats timeout.
        if (MemAckM || !MemReqM) begin
          state_d = RUN;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + WAIT_ONE;
          if (wcnt_d == WAIT_LIMIT) begin
            state_d = HALT;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // Priority: reset bubble > halt/memory wait freeze > taken branch > load-use.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if ((state_q == HALT) || mem_wait) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.stall_e = 1'b1;
      ctrl.stall_m = 1'b1;
      ctrl.flush_w = 1'b1;
    end else if (PCSrcE) begin
      ctrl.flush_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end else if (lw_stall) begin
      ctrl.stall_f = 1'b1;
      ctrl.stall_d = 1'b1;
      ctrl.flush_e = 1'b1;
    end
  end

  assign StallF = ctrl.stall_f;
  assign StallD = ctrl.stall_d;
  assign StallE = ctrl.stall_e;
  assign StallM = ctrl.stall_m;
  assign FlushD = ctrl.flush_d;
  assign FlushE = ctrl.flush_e;
  assign FlushW = ctrl.flush_w;

  assign stall_cnt_d = ctrl.stall_f ? (stall_cnt_q + CNT_W'(1)) : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign HaltO       = (state_q == HALT);
  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_dt1_hazard_ctrl.sv
// Directed bench for dt1_hazard_ctrl: expectations are queued as each step is
// driven and popped for comparison mid-cycle, when the combinational outputs settle.
module tb_dt1_hazard_ctrl;

  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 32;

  // {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_NONE = 7'b0000_000;
  localparam logic [6:0] C_LW   = 7'b1100_010;
  localparam logic [6:0] C_BR   = 7'b0000_110;
  localparam logic [6:0] C_MEM  = 7'b1111_001;
  localparam logic [6:0] C_RST  = 7'b0000_111;

  typedef struct {
    string      tag;
    logic [6:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       halt;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic PCSrcE, RegWriteM, RegWriteW, MemReqM, MemAckM;
  logic [1:0] ForwardAE, ForwardBE;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, HaltO;
  logic [CNT_W-1:0] StallCycles;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  dt1_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .Rs1D       (Rs1D),
    .Rs2D       (Rs2D),
    .Rs1E       (Rs1E),
    .Rs2E       (Rs2E),
    .RdE        (RdE),
    .ResultSrcE (ResultSrcE),
    .PCSrcE     (PCSrcE),
    .RdM        (RdM),
    .RegWriteM  (RegWriteM),
    .RdW        (RdW),
    .RegWriteW  (RegWriteW),
    .MemReqM    (MemReqM),
    .MemAckM    (MemAckM),
    .ForwardAE  (ForwardAE),
    .ForwardBE  (ForwardBE),
    .StallF     (StallF),
    .StallD     (StallD),
    .StallE     (StallE),
    .StallM     (StallM),
    .FlushD     (FlushD),
    .FlushE     (FlushE),
    .FlushW     (FlushW),
    .HaltO      (HaltO),
    .StallCycles(StallCycles)
  );

  task automatic clr_in();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
    RdE = 5'd0; RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00;
    PCSrcE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemReqM = 1'b0; MemAckM = 1'b0;
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [4:0] rs1d, input logic [4:0] rs2d);
    ResultSrcE = 2'b01; RdE = rd; Rs1D = rs1d; Rs2D = rs2d;
  endtask

  // One clock: queue expectation, compare at negedge, then advance past the edge.
  task automatic cyc(input string tag, input logic [6:0] c, input logic [1:0] fa,
                     input logic [1:0] fb, input logic h);
    exp_t e;
    logic [6:0] obs;
    e.tag = tag; e.ctrl = c; e.fa = fa; e.fb = fb; e.halt = h; e.cnt = exp_cnt;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
    total++;
    assert (obs === e.ctrl) else begin
      bad++; $error("FAIL %s ctrl got=%b exp=%b", e.tag, obs, e.ctrl);
    end
    total++;
    assert (ForwardAE === e.fa) else begin
      bad++; $error("FAIL %s ForwardAE got=%b exp=%b", e.tag, ForwardAE, e.fa);
    end
    total++;
    assert (ForwardBE === e.fb) else begin
      bad++; $error("FAIL %s ForwardBE got=%b exp=%b", e.tag, ForwardBE, e.fb);
    end
    total++;
    assert (HaltO === e.halt) else begin
      bad++; $error("FAIL %s HaltO got=%b exp=%b", e.tag, HaltO, e.halt);
    end
    total++;
    assert (StallCycles === e.cnt) else begin
      bad++; $error("FAIL %s StallCycles got=%0d exp=%0d", e.tag, StallCycles, e.cnt);
    end
    @(posedge clk);
    #1;
    if (rst) exp_cnt = '0;
    else if (e.ctrl[6]) exp_cnt = exp_cnt + 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    clr_in();
    @(posedge clk);
    #1;

    // Reset with hazards present: bubbles everywhere, no stalls, no forwarding
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; Rs2E = 5'd5;
    MemReqM = 1'b1; PCSrcE = 1'b1; set_lw(5'd7, 5'd7, 5'd0);
    cyc("rst0", C_RST, 2'b00, 2'b00, 1'b0);
    cyc("rst1", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; clr_in();
    cyc("idle", C_NONE, 2'b00, 2'b00, 1'b0);

    // Forwarding
    RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5; Rs2E = 5'd0;
    cyc("fwd_m", C_NONE, 2'b10, 2'b00, 1'b0);
    RdM = 5'd0;
    cyc("fwd_w", C_NONE, 2'b01, 2'b00, 1'b0);
    RdM = 5'd5; Rs2E = 5'd5;
    cyc("fwd_mb", C_NONE, 2'b10, 2'b10, 1'b0);
    RegWriteM = 1'b0;
    cyc("fwd_wb", C_NONE, 2'b01, 2'b01, 1'b0);
    RegWriteW = 1'b0;
    cyc("fwd_none", C_NONE, 2'b00, 2'b00, 1'b0);
    RdW = 5'd0; RegWriteW = 1'b1; Rs1E = 5'd0;
    cyc("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    clr_in();

    // Load-use
    set_lw(5'd7, 5'd0, 5'd7);
    cyc("lw_use", C_LW, 2'b00, 2'b00, 1'b0);
    clr_in();
    cyc("lw_rel", C_NONE, 2'b00, 2'b00, 1'b0);
    set_lw(5'd0, 5'd0, 5'd0);
    cyc("lw_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    set_lw(5'd7, 5'd7, 5'd0); ResultSrcE = 2'b10;
    cyc("lw_notload", C_NONE, 2'b00, 2'b00, 1'b0);

    // Branch and load-use together: branch flush wins
    set_lw(5'd7, 5'd7, 5'd0); PCSrcE = 1'b1;
    cyc("br_lw", C_BR, 2'b00, 2'b00, 1'b0);
    clr_in();

    // Memory wait with branch held in Execute
    MemReqM = 1'b1; PCSrcE = 1'b1;
    cyc("mw1", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("mw2", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("mw3", C_MEM, 2'b00, 2'b00, 1'b0);
    MemAckM = 1'b1;
    cyc("mw_ack_br", C_BR, 2'b00, 2'b00, 1'b0);
    clr_in();
    cyc("mw_after", C_NONE, 2'b00, 2'b00, 1'b0);

    // Memory wait over a load-use: stall first, load-use after the ack
    MemReqM = 1'b1; set_lw(5'd9, 5'd9, 5'd0);
    cyc("mw_lw", C_MEM, 2'b00, 2'b00, 1'b0);
    MemAckM = 1'b1;
    cyc("mw_ack_lw", C_LW, 2'b00, 2'b00, 1'b0);
    clr_in();

    // Timeout into HALT; inputs ignored there
    MemReqM = 1'b1;
    cyc("to1", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("to2", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("to3", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("to4", C_MEM, 2'b00, 2'b00, 1'b0);
    MemAckM = 1'b1; RegWriteM = 1'b1; RdM = 5'd3; Rs1E = 5'd3; PCSrcE = 1'b1;
    cyc("halt0", C_MEM, 2'b00, 2'b00, 1'b1);
    clr_in();
    cyc("halt1", C_MEM, 2'b00, 2'b00, 1'b1);
    cyc("halt2", C_MEM, 2'b00, 2'b00, 1'b1);
    rst = 1'b1;
    cyc("halt_rst", C_RST, 2'b00, 2'b00, 1'b1);
    rst = 1'b0;
    cyc("post_halt", C_NONE, 2'b00, 2'b00, 1'b0);

    // Ack on the last permitted cycle beats the timeout
    MemReqM = 1'b1;
    cyc("ak1", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("ak2", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("ak3", C_MEM, 2'b00, 2'b00, 1'b0);
    MemAckM = 1'b1;
    cyc("ak4", C_NONE, 2'b00, 2'b00, 1'b0);
    clr_in();
    cyc("ak_after", C_NONE, 2'b00, 2'b00, 1'b0);

    // Abandoned request restarts the wait count
    MemReqM = 1'b1;
    cyc("ab1", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("ab2", C_MEM, 2'b00, 2'b00, 1'b0);
    MemReqM = 1'b0;
    cyc("ab_drop", C_NONE, 2'b00, 2'b00, 1'b0);
    MemReqM = 1'b1;
    cyc("ab3", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("ab4", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("ab5", C_MEM, 2'b00, 2'b00, 1'b0);
    MemAckM = 1'b1;
    cyc("ab_ack", C_NONE, 2'b00, 2'b00, 1'b0);
    clr_in();

    // Reset in the middle of a wait
    MemReqM = 1'b1;
    cyc("rw1", C_MEM, 2'b00, 2'b00, 1'b0);
    cyc("rw2", C_MEM, 2'b00, 2'b00, 1'b0);
    rst = 1'b1;
    cyc("rw_rst", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0; clr_in();
    cyc("rw_after", C_NONE, 2'b00, 2'b00, 1'b0);
    MemReqM = 1'b1;
    cyc("rw_again", C_MEM, 2'b00, 2'b00, 1'b0);
    clr_in();
    cyc("end", C_NONE, 2'b00, 2'b00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
